vram_write_arbiter: RTL and testbench

- Sits directly downstream of the console cursor/character block, between it and the single-port text video RAM.
- Captures each console write strobe (address + character) into a small FIFO and commits it to VRAM only in cycles when the video scan-out is not reading.
- Provides a sequential whole-screen clear engine, so the console never needs to drive the RAM directly.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_write_arbiter_if.sv | 38 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/vram_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the VRAM write arbiter.
package vram_pkg;

    localparam int ADDR_W         = 13;
    localparam int DATA_W         = 8;
    localparam int CELLS          = 1200;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ENTRY_W        = ADDR_W + DATA_W;

    // Last address written by the clear engine.
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Console, scan-out and VRAM signals of the write arbiter.
// Handshake: con_write is a level strobe and its rising edge requests one
// write; rd_en requests a read and rd_valid answers exactly one cycle later;
// no back-pressure exists, so reads always win and writes wait.
interface vram_write_arbiter_if;
    import vram_pkg::*;

    logic              con_write;
    logic [ADDR_W-1:0] con_addr;
    logic [DATA_W-1:0] con_char;
    logic              clr_start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              clr_busy;
    logic              overflow;
    arb_state_t        dbg_state;

    // Arbiter side.
    modport slave (
        input  con_write, con_addr, con_char, clr_start, rd_en, rd_addr, ram_rdata,
        output rd_data, rd_valid, ram_addr, ram_we, ram_wdata, clr_busy, overflow,
        output dbg_state
    );

    // Console / scan-out / RAM side.
    modport master (
        output con_write, con_addr, con_char, clr_start, rd_en, rd_addr, ram_rdata,
        input  rd_data, rd_valid, ram_addr, ram_we, ram_wdata, clr_busy, overflow,
        input  dbg_state
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update; reset discards every pending entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are meaningless until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the single VRAM port between scan-out reads, the screen-clear
// engine and queued console writes, in that priority order.
module vram_write_arbiter
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    vram_write_arbiter_if.slave  bus
);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               w_edge;
    logic [ENTRY_W-1:0] w_fifo_in;
    logic [ENTRY_W-1:0] w_fifo_out;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_clear_wr;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic               w_ram_we;
    logic [DATA_W-1:0]  w_ram_wdata;
    arb_state_t         r_state;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_clr_busy;
    logic               r_overflow;
    logic               r_rd_valid;
    logic [ADDR_W-1:0]  r_last_addr;

    // con_write is asynchronous; the address/char are quasi-static while it is high.
    assign w_edge    = r_sync2 & ~r_sync3;
    assign w_fifo_in = {bus.con_addr, bus.con_char};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_edge),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Two-flop synchronizer plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.con_write;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // RAM port arbitration: read, then clear, then queued console write.
    always_comb begin
        w_ram_addr  = r_last_addr;
        w_ram_we    = 1'b0;
        w_ram_wdata = '0;
        w_pop       = 1'b0;
        w_clear_wr  = 1'b0;
        if (bus.rd_en) begin
            w_ram_addr = bus.rd_addr;
        end else if (r_state == ST_CLEAR) begin
            w_ram_addr = r_clr_cnt;
            w_ram_we   = 1'b1;
            w_clear_wr = 1'b1;
        end else if (!w_empty) begin
            w_ram_addr  = w_fifo_out[ENTRY_W-1:DATA_W];
            w_ram_wdata = w_fifo_out[DATA_W-1:0];
            w_ram_we    = 1'b1;
            w_pop       = 1'b1;
        end
    end

    // Clear engine: the counter only advances on cycles the clear write wins the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_clr_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        r_state    <= ST_CLEAR;
                        r_clr_cnt  <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (w_clear_wr) begin
                        if (r_clr_cnt == LAST_CELL) begin
                            r_state    <= ST_IDLE;
                            r_clr_busy <= 1'b0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow, read-valid pipeline and the held idle address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_overflow  <= r_overflow | (w_edge & w_full);
            r_rd_valid  <= bus.rd_en;
            r_last_addr <= w_ram_addr;
        end
    end

    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_wdata = w_ram_wdata;
    // The RAM's own output register is the read pipeline stage; gate it by valid.
    assign bus.rd_data   = r_rd_valid ? bus.ram_rdata : '0;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.clr_busy  = r_clr_busy;
    assign bus.overflow  = r_overflow;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: RAM model, write/read scoreboard, vectors.
module tb_vram_write_arbiter;
    import vram_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_write_arbiter_if bus ();

    vram_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [ENTRY_W-1:0] exp_q[$];
    logic [DATA_W-1:0]  rd_q[$];
    logic [DATA_W-1:0]  mem [1 << ADDR_W];
    logic               rd_en_prev = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] ch;
        logic              exp_overflow;
    } wr_vec_t;

    wr_vec_t vecs [5];
    wr_vec_t ovf [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic con_strobe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] c);
        bus.con_addr  = a;
        bus.con_char  = c;
        bus.con_write = 1'b1;
        tick(4);
        bus.con_write = 1'b0;
        tick(3);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        tick(2);
        check(name, exp_q.size(), 0);
    endtask

    task automatic push_clear_entries();
        for (int i = 0; i < CELLS; i++) exp_q.push_back({ADDR_W'(i), DATA_W'(0)});
    endtask

    // Single-port VRAM model with 1-cycle synchronous read.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Monitor sampled between edges: reads, read latency, write ordering.
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            rd_en_prev = 1'b0;
            rd_q.delete();
        end else begin
            check("rd_valid_latency", bus.rd_valid, rd_en_prev);
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=valid required=none");
                end else begin
                    check("rd_data", bus.rd_data, rd_q.pop_front());
                end
            end
            if (bus.rd_en) begin
                check("no_write_during_read", bus.ram_we, 1'b0);
                rd_q.push_back(mem[bus.rd_addr]);
            end
            if (bus.ram_we) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_unexpected actual=%0h/%0h required=none",
                             bus.ram_addr, bus.ram_wdata);
                end else begin
                    check("ram_write", {bus.ram_addr, bus.ram_wdata}, exp_q.pop_front());
                end
            end
            rd_en_prev = bus.rd_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int base;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i) ^ 8'h5a;
        vecs[0] = '{13'h0029, 8'h41, 1'b0};
        vecs[1] = '{13'h0000, 8'h7e, 1'b0};
        vecs[2] = '{13'h1fff, 8'hff, 1'b0};
        vecs[3] = '{13'h04af, 8'h00, 1'b0};
        vecs[4] = '{ADDR_W'($urandom_range(64, 8000)), DATA_W'($urandom_range(1, 255)), 1'b0};
        for (int i = 0; i < 5; i++)
            ovf[i] = '{ADDR_W'(16'h0200 + i * 3), DATA_W'(8'hc0 + i), 1'b0};

        // Reset state.
        reset = 1'b1;
        bus.con_write = 1'b0; bus.con_addr = '0; bus.con_char = '0;
        bus.clr_start = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        tick(3);
        #2;
        check("rst_ram_we", bus.ram_we, 1'b0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_clr_busy", bus.clr_busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        tick(1);
        reset = 1'b0;
        tick(2);

        // Table: single writes, exact capture latency.
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back({vecs[v].addr, vecs[v].ch});
            bus.con_addr  = vecs[v].addr;
            bus.con_char  = vecs[v].ch;
            bus.con_write = 1'b1;
            tick(2);
            #2 check("lat_early", bus.ram_we, 1'b0);
            tick(1);
            #2;
            check("lat_we", bus.ram_we, 1'b1);
            check("lat_addr", bus.ram_addr, vecs[v].addr);
            check("lat_data", bus.ram_wdata, vecs[v].ch);
            tick(2);
            bus.con_write = 1'b0;
            tick(3);
            check("vec_overflow", bus.overflow, vecs[v].exp_overflow);
        end
        wait_drain("single_drain", 20);

        // Read priority over a pending FIFO entry.
        exp_q.push_back({13'h0100, 8'h33});
        bus.con_addr = 13'h0100;
        bus.con_char = 8'h33;
        for (int k = 0; k < 10; k++) begin
            bus.rd_en     = 1'b1;
            bus.rd_addr   = (k == 0) ? 13'h0029 : ADDR_W'($urandom_range(0, 8191));
            bus.con_write = (k < 5);
            tick(1);
        end
        bus.rd_en = 1'b0;
        #2;
        check("rdprio_we", bus.ram_we, 1'b1);
        check("rdprio_addr", bus.ram_addr, 13'h0100);
        check("rdprio_data", bus.ram_wdata, 8'h33);
        wait_drain("rdprio_drain", 10);

        // Full clear with a second clr_start mid-way.
        push_clear_entries();
        bus.clr_start = 1'b1;
        tick(1);
        bus.clr_start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            #2;
            if (!bus.clr_busy) break;
            busy_cnt++;
            bus.clr_start = (c == 600);
            @(negedge clk);
        end
        bus.clr_start = 1'b0;
        check("clr_busy_cycles", busy_cnt, CELLS);
        wait_drain("clear_drain", 10);

        // Clear interleaved with reads, console write mid-clear.
        push_clear_entries();
        exp_q.push_back({13'd5, 8'h42});
        for (int c = 0; c < 5000; c++) begin
            bus.clr_start = (c == 0);
            bus.rd_en     = (c % 2 == 1);
            bus.rd_addr   = ADDR_W'($urandom_range(0, 8191));
            if (c == 500) begin
                bus.con_addr  = 13'd5;
                bus.con_char  = 8'h42;
                bus.con_write = 1'b1;
            end
            if (c == 505) bus.con_write = 1'b0;
            tick(1);
            if (c > 0 && !bus.clr_busy) break;
        end
        bus.rd_en = 1'b0;
        bus.clr_start = 1'b0;
        wait_drain("interleave_drain", 20);
        check("model_ram5", mem[5], 8'h42);
        check("model_ram4", mem[4], 8'h00);
        check("model_ram1199", mem[1199], 8'h00);

        // Overflow with reads stalling the port.
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd_addr = ADDR_W'($urandom_range(0, 8191));
            if (i < DEPTH) exp_q.push_back({ovf[i].addr, ovf[i].ch});
            con_strobe(ovf[i].addr, ovf[i].ch);
            check("ovf_flag", bus.overflow, (i >= DEPTH));
        end
        bus.rd_en = 1'b0;
        wait_drain("ovf_drain", 20);
        check("ovf_sticky", bus.overflow, 1'b1);

        // Async reset at clear address 300 with a pending console write.
        push_clear_entries();
        base = writes_seen;
        bus.clr_start = 1'b1;
        tick(1);
        bus.clr_start = 1'b0;
        for (int c = 0; c < 2000 && (writes_seen - base) < 300; c++) begin
            if (writes_seen - base == 100) begin
                bus.con_addr  = 13'h0077;
                bus.con_char  = 8'h99;
                bus.con_write = 1'b1;
            end
            tick(1);
        end
        check("reset_point", writes_seen - base, 300);
        reset = 1'b1;
        bus.con_write = 1'b0;
        #1;
        check("rstmid_we", bus.ram_we, 1'b0);
        check("rstmid_busy", bus.clr_busy, 1'b0);
        check("rstmid_state", bus.dbg_state, ST_IDLE);
        check("rstmid_overflow", bus.overflow, 1'b0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        base = writes_seen;
        tick(50);
        check("no_writes_after_reset", writes_seen - base, 0);
        check("post_reset_busy", bus.clr_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
